// File: rtl/gpr_rd_arbiter_pkg.sv
// ============================================================================
// gpr_rd_arbiter_pkg
//   Shared constants and types for the GPR slice-bank read-port arbiter and
//   the operand collectors that feed it.
//
//   - Register-file geometry (XLEN, register id width, warp-slot width).
//   - GPR_RAM_ADDRW: bank address width, laid out as {wis, rid}.
//   - gpr_rd_req_t: one read request as produced by an operand collector.
//   - lock_state_e: state of the burst lock held by one requester.
// ============================================================================
package gpr_rd_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_REGS      = 32;
    localparam int NR_BITS       = 5;

    // Number of warp-slot bits folded into the bank address. With zero the
    // bank holds one warp slot and is addressed by the register id alone;
    // the wis ports still exist (one bit wide) but are ignored.
    localparam int ISSUE_WIS     = 2;
    localparam int ISSUE_WIS_W   = (ISSUE_WIS > 0) ? ISSUE_WIS : 1;

    localparam int GPR_RAM_ADDRW = ISSUE_WIS + NR_BITS;
    localparam int PERF_CTR_BITS = 44;

    localparam int GPR_TAG_WIDTH = 2;

    typedef struct packed {
        logic [ISSUE_WIS_W-1:0]   wis;
        logic [NR_BITS-1:0]       rid;
        logic [GPR_TAG_WIDTH-1:0] tag;
        logic                     last;
    } gpr_rd_req_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/gpr_rd_arbiter_if.sv
// ============================================================================
// gpr_rd_arbiter_if
//   Request/response bus between NUM_REQS operand collectors and the bank
//   read-port arbiter.
//
//   master (collector side): drives req_valid/req_wis/req_rid/req_tag/
//                            req_last, receives req_ready and the rsp_* bus.
//   slave  (arbiter side)  : the mirror image.
//
//   req_ready is a combinational grant; rsp_* has no backpressure and
//   arrives one cycle after the grant.
// ============================================================================
interface gpr_rd_arbiter_if #(
    parameter int NUM_REQS    = 4,
    parameter int TAG_WIDTH   = 2,
    parameter int NUM_THREADS = 4
) ();
    import gpr_rd_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]                        req_valid;
    logic [NUM_REQS-1:0][ISSUE_WIS_W-1:0]       req_wis;
    logic [NUM_REQS-1:0][NR_BITS-1:0]           req_rid;
    logic [NUM_REQS-1:0][TAG_WIDTH-1:0]         req_tag;
    logic [NUM_REQS-1:0]                        req_last;
    logic [NUM_REQS-1:0]                        req_ready;

    logic                                       rsp_valid;
    logic [IDX_W-1:0]                           rsp_idx;
    logic [TAG_WIDTH-1:0]                       rsp_tag;
    logic [NUM_THREADS-1:0][XLEN-1:0]           rsp_data;

    modport master (
        output req_valid, req_wis, req_rid, req_tag, req_last,
        input  req_ready,
        input  rsp_valid, rsp_idx, rsp_tag, rsp_data
    );

    modport slave (
        input  req_valid, req_wis, req_rid, req_tag, req_last,
        output req_ready,
        output rsp_valid, rsp_idx, rsp_tag, rsp_data
    );

endinterface

// File: rtl/gpr_rd_arbiter_rr.sv
// ============================================================================
// gpr_rd_arbiter_rr
//   Round-robin grant selector.
//
//   clk, reset    : clock and synchronous active-high reset
//   requests      : request vector (already masked by any lock upstream)
//   advance       : when a grant issues with advance=1 the priority pointer
//                   moves to the requester after the granted one
//   grant_valid   : some request was granted
//   grant_index   : granted requester
//   grant_onehot  : one-hot form of the grant (zero when none)
//
//   Priority starts at requester 0 after reset. Holding the pointer during a
//   non-advancing grant is what lets a burst owner keep first place once its
//   lock is released only on the final beat.
// ============================================================================
module gpr_rd_arbiter_rr #(
    parameter int NUM_REQS = 4,
    localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                advance,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_index,
    output logic [NUM_REQS-1:0] grant_onehot
);

    generate
        if (NUM_REQS == 1) begin : g_single
            // One requester: nothing to rotate, pointer is implicitly 0.
            assign grant_valid = requests[0];
            assign grant_index = '0;
        end else begin : g_multi
            logic [IDX_W-1:0]                ptr_reg;
            logic [NUM_REQS-1:0][IDX_W-1:0]  rot_idx;
            logic [NUM_REQS-1:0]             rot_req;

            // Position gi of the rotated view is requester (ptr + gi) mod N,
            // so the lowest active position is the round-robin winner.
            for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rot
                logic [IDX_W:0] sum;
                assign sum = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
                assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQS))
                                   ? IDX_W'(sum - (IDX_W+1)'(NUM_REQS))
                                   : sum[IDX_W-1:0];
                assign rot_req[gi] = requests[rot_idx[gi]];
            end

            // Scan from the far end so the lowest rotated position wins.
            always_comb begin
                grant_valid = 1'b0;
                grant_index = '0;
                for (int k = NUM_REQS - 1; k >= 0; k--) begin
                    if (rot_req[k]) begin
                        grant_valid = 1'b1;
                        grant_index = rot_idx[k];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr_reg <= '0;
                end else if (grant_valid && advance) begin
                    ptr_reg <= (grant_index == IDX_W'(NUM_REQS - 1))
                             ? '0 : grant_index + IDX_W'(1);
                end
            end
        end
    endgenerate

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
        assign grant_onehot[gi] = grant_valid && (grant_index == IDX_W'(gi));
    end

endmodule

// File: rtl/gpr_rd_arbiter.sv
// ============================================================================
// gpr_rd_arbiter
//   Read-port arbiter and sequencer for one single-read-port GPR slice bank.
//
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : NUM_REQS collector requests in, grant (req_ready) and
//                      tagged response out (see gpr_rd_arbiter_if)
//   wb_valid/wis/rid/tmask/data : snoop of the bank write port
//   ram_raddr        : registered bank read address {wis, rid}
//   ram_rdata        : bank data, valid the cycle after ram_raddr loads
//   perf_conflicts   : count of cycles where a valid requester went ungranted
//
//   A requester that is granted with req_last=0 locks the port until its
//   last beat is granted. The bank has no read-during-write check, so a
//   writeback to the granted address in the grant cycle is captured and
//   merged into the response per lane. Register 0 always reads as zero.
// ============================================================================
module gpr_rd_arbiter
    import gpr_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int TAG_WIDTH   = 2,
    parameter int NUM_THREADS = 4,
    parameter int RAM_ADDRW   = GPR_RAM_ADDRW
) (
    input  logic                               clk,
    input  logic                               reset,
    gpr_rd_arbiter_if.slave                    bus,
    input  logic                               wb_valid,
    input  logic [ISSUE_WIS_W-1:0]             wb_wis,
    input  logic [NR_BITS-1:0]                 wb_rid,
    input  logic [NUM_THREADS-1:0]             wb_tmask,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]   wb_data,
    output logic [RAM_ADDRW-1:0]               ram_raddr,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]   ram_rdata,
    output logic [PERF_CTR_BITS-1:0]           perf_conflicts
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    // ------------------------------------------------------------------
    // Lock state and grant selection
    // ------------------------------------------------------------------
    lock_state_e           state_reg;
    logic [IDX_W-1:0]      owner_reg;

    logic [NUM_REQS-1:0]   owner_mask;
    logic [NUM_REQS-1:0]   arb_req;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_REQS-1:0]   grant_onehot;
    logic                  grant_last;
    logic [NR_BITS-1:0]    grant_rid;
    logic [RAM_ADDRW-1:0]  grant_addr;
    logic [RAM_ADDRW-1:0]  wb_addr;
    logic                  fwd_hit;
    logic                  conflict;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_owner
        assign owner_mask[gi] = (owner_reg == IDX_W'(gi));
    end

    // While locked only the owner competes; if it is not valid nobody is
    // granted. No grants are offered during reset so a requester never sees
    // a ready whose response would be dropped.
    always_comb begin
        arb_req = bus.req_valid;
        if (reset) begin
            arb_req = '0;
        end else if (state_reg == ST_LOCKED) begin
            arb_req = bus.req_valid & owner_mask;
        end
    end

    assign grant_last = bus.req_last[grant_idx];
    assign grant_rid  = bus.req_rid[grant_idx];

    gpr_rd_arbiter_rr #(
        .NUM_REQS (NUM_REQS)
    ) u_rr (
        .clk          (clk),
        .reset        (reset),
        .requests     (arb_req),
        .advance      (grant_last),
        .grant_valid  (grant_valid),
        .grant_index  (grant_idx),
        .grant_onehot (grant_onehot)
    );

    assign bus.req_ready = grant_onehot;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid && !grant_last) begin
                        state_reg <= ST_LOCKED;
                        owner_reg <= grant_idx;
                    end
                end
                ST_LOCKED: begin
                    if (grant_valid && grant_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bank address composition
    // ------------------------------------------------------------------
    generate
        if (ISSUE_WIS > 0) begin : g_wis
            assign grant_addr = {bus.req_wis[grant_idx], grant_rid};
            assign wb_addr    = {wb_wis, wb_rid};
        end else begin : g_no_wis
            assign grant_addr = grant_rid;
            assign wb_addr    = wb_rid;
        end
    endgenerate

    // Only a write landing in the grant cycle races the bank read.
    assign fwd_hit = wb_valid && (wb_addr == grant_addr);

    // ------------------------------------------------------------------
    // Read launch, forward latch and response register
    // ------------------------------------------------------------------
    logic                              rsp_valid_reg;
    logic [IDX_W-1:0]                  rsp_idx_reg;
    logic [TAG_WIDTH-1:0]              rsp_tag_reg;
    logic [RAM_ADDRW-1:0]              raddr_reg;
    logic                              zero_reg;
    logic [NUM_THREADS-1:0]            fwd_tmask_reg;
    logic [NUM_THREADS-1:0][XLEN-1:0]  fwd_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_idx_reg   <= '0;
            rsp_tag_reg   <= '0;
            raddr_reg     <= '0;
            zero_reg      <= 1'b0;
            fwd_tmask_reg <= '0;
            fwd_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= grant_valid;
            if (grant_valid) begin
                rsp_idx_reg   <= grant_idx;
                rsp_tag_reg   <= bus.req_tag[grant_idx];
                raddr_reg     <= grant_addr;
                zero_reg      <= (grant_rid == '0);
                fwd_tmask_reg <= fwd_hit ? wb_tmask : '0;
                fwd_data_reg  <= wb_data;
            end
        end
    end

    assign ram_raddr     = raddr_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_idx   = rsp_idx_reg;
    assign bus.rsp_tag   = rsp_tag_reg;

    // Per-lane merge: zero register beats forwarding, forwarding beats RAM.
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
        assign bus.rsp_data[gi] = zero_reg            ? '0
                                : fwd_tmask_reg[gi]   ? fwd_data_reg[gi]
                                :                       ram_rdata[gi];
    end

    // ------------------------------------------------------------------
    // Conflict counter (free-running, wraps)
    // ------------------------------------------------------------------
    logic [PERF_CTR_BITS-1:0] perf_reg;

    assign conflict = |(bus.req_valid & ~grant_onehot);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reg <= '0;
        end else if (conflict) begin
            perf_reg <= perf_reg + PERF_CTR_BITS'(1);
        end
    end

    assign perf_conflicts = perf_reg;

endmodule

// File: tb/tb_gpr_rd_arbiter.sv
// ============================================================================
// tb_gpr_rd_arbiter
//   Bench for gpr_rd_arbiter: directed vector table, hand-written corner
//   sequences (forwarding, late write, zero register, reset mid-burst) and a
//   randomized run, all cross-checked against a behavioural model.
// ============================================================================
module tb_gpr_rd_arbiter;
    import gpr_rd_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int TW = 2;
    localparam int NT = 4;
    localparam int AW = GPR_RAM_ADDRW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpr_rd_arbiter_if #(.NUM_REQS(NR), .TAG_WIDTH(TW), .NUM_THREADS(NT)) bus ();

    logic                         wb_valid;
    logic [ISSUE_WIS_W-1:0]       wb_wis;
    logic [NR_BITS-1:0]           wb_rid;
    logic [NT-1:0]                wb_tmask;
    logic [NT-1:0][XLEN-1:0]      wb_data;
    logic [AW-1:0]                ram_raddr;
    logic [NT-1:0][XLEN-1:0]      ram_rdata;
    logic [PERF_CTR_BITS-1:0]     perf_conflicts;

    gpr_rd_arbiter #(
        .NUM_REQS    (NR),
        .TAG_WIDTH   (TW),
        .NUM_THREADS (NT),
        .RAM_ADDRW   (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .wb_valid       (wb_valid),
        .wb_wis         (wb_wis),
        .wb_rid         (wb_rid),
        .wb_tmask       (wb_tmask),
        .wb_data        (wb_data),
        .ram_raddr      (ram_raddr),
        .ram_rdata      (ram_rdata),
        .perf_conflicts (perf_conflicts)
    );

    // Static bank contents; writebacks are only snooped, never stored, so
    // lanes that are not forwarded keep showing the old value.
    function automatic logic [XLEN-1:0] ram_val(input logic [AW-1:0] a, input int j);
        if (a == AW'(7'h25)) return 32'h0000_00A5;
        return 32'h1000_0000 | (32'(a) << 8) | 32'(j);
    endfunction

    always_comb begin
        for (int j = 0; j < NT; j++) ram_rdata[j] = ram_val(ram_raddr, j);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                        m_ptr;
    int                        m_owner;     // -1 when unlocked
    bit                        m_pv;
    int                        m_pidx;
    int                        m_ptag;
    logic [NT-1:0][XLEN-1:0]   m_pdata;
    logic [AW-1:0]             m_raddr;
    logic [PERF_CTR_BITS-1:0]  m_perf;

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_pv = 0; m_pidx = 0; m_ptag = 0;
        m_pdata = '0; m_raddr = '0; m_perf = '0;
    endtask

    function automatic int model_grant();
        if (reset) return -1;
        if (m_owner >= 0) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            if (bus.req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs driven; compares, advances the model,
    // and returns at the next posedge+1.
    task automatic do_cycle(output int g);
        logic [AW-1:0] a;
        logic [NR-1:0] exp_rdy;
        #3;
        g = model_grant();
        exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("rsp_valid", bus.rsp_valid, m_pv);
        chk("rsp_idx", bus.rsp_idx, m_pidx);
        chk("rsp_tag", bus.rsp_tag, m_ptag);
        if (m_pv) chk("rsp_data", bus.rsp_data, m_pdata);
        chk("ram_raddr", ram_raddr, m_raddr);
        chk("perf_conflicts", perf_conflicts, m_perf);
        if (reset) begin
            model_reset();
        end else begin
            if ((bus.req_valid & ~exp_rdy) != '0) m_perf = m_perf + 1'b1;
            m_pv = (g >= 0);
            if (g >= 0) begin
                a = {bus.req_wis[g], bus.req_rid[g]};
                m_raddr = a;
                m_pidx  = g;
                m_ptag  = int'(bus.req_tag[g]);
                for (int j = 0; j < NT; j++) begin
                    if (bus.req_rid[g] == '0)
                        m_pdata[j] = '0;
                    else if (wb_valid && ({wb_wis, wb_rid} == a) && wb_tmask[j])
                        m_pdata[j] = wb_data[j];
                    else
                        m_pdata[j] = ram_val(a, j);
                end
                if (bus.req_last[g]) begin
                    m_ptr = (g + 1) % NR;
                    m_owner = -1;
                end else begin
                    m_owner = g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NR-1:0] v, input logic [NR-1:0] l,
                           input logic [ISSUE_WIS_W-1:0] w, input logic [NR_BITS-1:0] r,
                           input logic [TW-1:0] t);
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < NR; i++) begin
            bus.req_wis[i] = w;
            bus.req_rid[i] = r;
            bus.req_tag[i] = t;
        end
    endtask

    task automatic set_wb(input logic v, input logic [ISSUE_WIS_W-1:0] w,
                          input logic [NR_BITS-1:0] r, input logic [NT-1:0] m,
                          input logic [XLEN-1:0] d);
        wb_valid = v; wb_wis = w; wb_rid = r; wb_tmask = m;
        for (int j = 0; j < NT; j++) wb_data[j] = d;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                   rst;
        logic [NR-1:0]          valid;
        logic [NR-1:0]          last;
        logic [ISSUE_WIS_W-1:0] wis;
        logic [NR_BITS-1:0]     rid;
        logic [TW-1:0]          tag;
        logic [NR-1:0]          exp_ready;
        logic                   exp_rv;
        logic [1:0]             exp_ri;
        logic [TW-1:0]          exp_rt;
        logic                   chk_d;
        logic [XLEN-1:0]        exp_d;
    } vec_t;

    vec_t vt[$];

    initial begin
        int g;

        // Single request, response one cycle later with RAM word 0xA5.
        vt.push_back('{1'b0, 4'b0100, 4'b1111, 2'd1, 5'd5, 2'd3, 4'b0100, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0000, 4'b1111, 2'd0, 5'd0, 2'd0, 4'b0000, 1'b1, 2'd2, 2'd3, 1'b1, 32'hA5});
        // Fairness from pointer 0 with every requester asking.
        vt.push_back('{1'b1, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0001, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0010, 1'b1, 2'd0, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0100, 1'b1, 2'd1, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b1000, 1'b1, 2'd2, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b1111, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0001, 1'b1, 2'd3, 2'd1, 1'b0, 32'h0});
        // Lock: requester 1 bursts 3 beats, idles once mid-burst.
        vt.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 5'd9, 2'd1, 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0010, 4'b0000, 2'd0, 5'd9, 2'd1, 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0011, 4'b0000, 2'd0, 5'd9, 2'd1, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0001, 4'b0000, 2'd0, 5'd9, 2'd1, 4'b0000, 1'b1, 2'd1, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0011, 4'b0010, 2'd0, 5'd9, 2'd1, 4'b0010, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0011, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0001, 1'b1, 2'd1, 2'd1, 1'b0, 32'h0});
        vt.push_back('{1'b0, 4'b0000, 4'b1111, 2'd0, 5'd9, 2'd1, 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0, 32'h0});

        // ---- reset ----
        reset = 1'b1;
        set_req('0, '0, '0, '0, '0);
        set_wb(1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_idx", bus.rsp_idx, 2'd0);
        chk("reset_rsp_tag", bus.rsp_tag, 2'd0);
        chk("reset_ram_raddr", ram_raddr, 7'd0);
        chk("reset_perf", perf_conflicts, 44'd0);

        // ---- table ----
        for (int k = 0; k < vt.size(); k++) begin
            reset = vt[k].rst;
            set_req(vt[k].valid, vt[k].last, vt[k].wis, vt[k].rid, vt[k].tag);
            #2;
            chk($sformatf("vec%0d_ready", k), bus.req_ready, vt[k].exp_ready);
            chk($sformatf("vec%0d_rsp_valid", k), bus.rsp_valid, vt[k].exp_rv);
            if (vt[k].exp_rv) begin
                chk($sformatf("vec%0d_rsp_idx", k), bus.rsp_idx, vt[k].exp_ri);
                chk($sformatf("vec%0d_rsp_tag", k), bus.rsp_tag, vt[k].exp_rt);
            end
            if (vt[k].chk_d)
                chk($sformatf("vec%0d_rsp_data", k), bus.rsp_data, {NT{vt[k].exp_d}});
            do_cycle(g);
        end
        reset = 1'b0;

        // ---- forwarding in the grant cycle ----
        set_req(4'b0001, 4'b1111, 2'd0, 5'd7, 2'd2);
        set_wb(1'b1, 2'd0, 5'd7, 4'b0101, 32'h11);
        do_cycle(g);
        set_req('0, '0, '0, '0, '0);
        set_wb(1'b0, '0, '0, '0, '0);
        chk("fwd_data", bus.rsp_data, {32'h1000_0703, 32'h11, 32'h1000_0701, 32'h11});
        do_cycle(g);

        // ---- write one cycle after the grant is not forwarded ----
        set_req(4'b0001, 4'b1111, 2'd0, 5'd7, 2'd2);
        do_cycle(g);
        set_req('0, '0, '0, '0, '0);
        set_wb(1'b1, 2'd0, 5'd7, 4'b1111, 32'h11);
        #1;
        chk("late_wb_data", bus.rsp_data, {32'h1000_0703, 32'h1000_0702, 32'h1000_0701, 32'h1000_0700});
        do_cycle(g);
        set_wb(1'b0, '0, '0, '0, '0);

        // ---- zero register ignores RAM and forwarding ----
        set_req(4'b0001, 4'b1111, 2'd0, 5'd0, 2'd0);
        set_wb(1'b1, 2'd0, 5'd0, 4'b1111, 32'hFFFF_FFFF);
        do_cycle(g);
        set_req('0, '0, '0, '0, '0);
        set_wb(1'b0, '0, '0, '0, '0);
        chk("zero_rsp_valid", bus.rsp_valid, 1'b1);
        chk("zero_rsp_data", bus.rsp_data, 128'd0);
        do_cycle(g);

        // ---- reset right after a non-last grant ----
        set_req(4'b0010, 4'b0000, 2'd0, 5'd3, 2'd1);
        do_cycle(g);
        reset = 1'b1;
        set_req(4'b0011, 4'b0000, 2'd0, 5'd3, 2'd1);
        #1;
        chk("rst_mid_pending_rsp", bus.rsp_valid, 1'b1);
        chk("rst_mid_no_grant", bus.req_ready, 4'b0000);
        do_cycle(g);
        reset = 1'b0;
        set_req(4'b0011, 4'b1111, 2'd0, 5'd3, 2'd1);
        #1;
        chk("rst_after_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_after_priority", bus.req_ready, 4'b0001);
        do_cycle(g);
        set_req('0, '0, '0, '0, '0);
        do_cycle(g);

        // ---- randomized run against the model ----
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NR; i++) begin
                bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                bus.req_last[i]  = ($urandom_range(0, 1) != 0);
                bus.req_wis[i]   = ISSUE_WIS_W'($urandom_range(0, 1));
                bus.req_rid[i]   = NR_BITS'($urandom_range(0, 3));
                bus.req_tag[i]   = TW'($urandom);
            end
            wb_valid = ($urandom_range(0, 1) != 0);
            wb_wis   = ISSUE_WIS_W'($urandom_range(0, 1));
            wb_rid   = NR_BITS'($urandom_range(0, 3));
            wb_tmask = NT'($urandom);
            for (int j = 0; j < NT; j++) wb_data[j] = $urandom;
            do_cycle(g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
